uart_cmd_ctrl: RTL and testbench

Sequences a UART receiver: consumes each received byte with the rdy/clr_rdy handshake and assembles NUM_BYTES consecutive bytes into one command word. It presents the word to the command processor with a cmd_rdy/clr_cmd_rdy handshake. It discards partial frames after an inter-byte timeout and flags frames lost to overrun. It sits between the UART receiver and the command-processing logic.

---
 rtl/uart_cmd_ctrl_if.sv | 24 ++
 rtl/uart_cmd_ctrl.sv | 89 ++++++++
 tb/tb_uart_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Handshake bundle between the UART receiver, the frame assembler and the command consumer.
// The slave side is the assembler; the master side is whatever drives rx bytes and acks commands.
interface uart_cmd_ctrl_if #(
    parameter int NUM_BYTES = 2
);
    logic                   rdy;
    logic [7:0]             rx_data;
    logic                   clr_rdy;
    logic [8*NUM_BYTES-1:0] cmd;
    logic                   cmd_rdy;
    logic                   clr_cmd_rdy;
    logic                   overrun;
    logic                   timeout;

    modport master (
        output rdy, rx_data, clr_cmd_rdy,
        input  clr_rdy, cmd, cmd_rdy, overrun, timeout
    );

    modport slave (
        input  rdy, rx_data, clr_cmd_rdy,
        output clr_rdy, cmd, cmd_rdy, overrun, timeout
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Assembles NUM_BYTES received UART bytes into one command word, first byte in the MSBs,
// with an inter-byte timeout for partial frames and overrun flagging for unacknowledged commands.
module uart_cmd_ctrl #(
    parameter int NUM_BYTES   = 2,
    parameter int TIMEOUT_CYC = 78120
) (
    input logic            clk,
    input logic            rst_n,
    uart_cmd_ctrl_if.slave bus
);

    localparam int CMD_W = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int BC_W  = 3;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state_q, state_d;
    logic [BC_W-1:0]    byte_cnt_q;
    logic [CNT_W-1:0]   to_cnt_q;
    logic [CMD_W-1:0]   asm_q;
    logic [CMD_W-1:0]   asm_next;
    logic               last_byte;
    logic               tc_hit;
    logic               load_cmd;
    logic               drop_frame;

    // Size cast keeps the low CMD_W bits, so this also covers NUM_BYTES == 1.
    assign asm_next  = CMD_W'({asm_q, bus.rx_data});
    assign last_byte = bus.rdy && (byte_cnt_q == BC_W'(NUM_BYTES - 1));
    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign tc_hit    = (state_q == COLLECT) && !bus.rdy && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.rdy && !last_byte) state_d = COLLECT;
            COLLECT: if (last_byte || tc_hit)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.clr_rdy = bus.rdy;
        load_cmd    = last_byte && (!bus.cmd_rdy || bus.clr_cmd_rdy);
        drop_frame  = last_byte && bus.cmd_rdy && !bus.clr_cmd_rdy;
    end

    // NOTE: every register here is a plain flop, so all of them are reset; nothing is left to power-up value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            asm_q       <= '0;
            bus.cmd     <= '0;
            bus.cmd_rdy <= 1'b0;
            bus.overrun <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.overrun <= drop_frame;
            bus.timeout <= tc_hit;

            if (last_byte || tc_hit) byte_cnt_q <= '0;
            else if (bus.rdy)        byte_cnt_q <= byte_cnt_q + 1'b1;

            if (tc_hit)       asm_q <= '0;
            else if (bus.rdy) asm_q <= asm_next;

            // Idle clocks are only counted while a frame is partially collected.
            if (state_q == COLLECT && !bus.rdy && !tc_hit) to_cnt_q <= to_cnt_q + 1'b1;
            else                                          to_cnt_q <= '0;

            if (load_cmd) begin
                bus.cmd     <= asm_next;
                bus.cmd_rdy <= 1'b1;
            end else if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: vector table, hand-written corner sequences, and randomized
// traffic against a byte-queue reference model; also covers the 1-byte and 4-byte frame variants.
module tb_uart_cmd_ctrl;

    localparam int NB = 2;
    localparam int T  = 120;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.NUM_BYTES(NB)) b2 ();
    uart_cmd_ctrl_if #(.NUM_BYTES(1))  b1 ();
    uart_cmd_ctrl_if #(.NUM_BYTES(4))  b4 ();

    uart_cmd_ctrl #(.NUM_BYTES(NB), .TIMEOUT_CYC(T)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    uart_cmd_ctrl #(.NUM_BYTES(1))                   dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    uart_cmd_ctrl #(.NUM_BYTES(4))                   dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of bytes; it is abandoned on its T-th consecutive idle clock.
    logic [7:0]  frame_q[$];
    int          idle;
    logic [15:0] m_cmd;
    logic        m_rdy, m_ovr, m_to;

    task automatic model_reset();
        frame_q.delete();
        idle  = 0;
        m_cmd = '0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic model_cycle(input logic r, input logic [7:0] d, input logic c);
        logic        done;
        logic [15:0] word;
        done  = 1'b0;
        word  = '0;
        m_ovr = 1'b0;
        m_to  = 1'b0;
        if (r) begin
            frame_q.push_back(d);
            idle = 0;
            if (frame_q.size() == NB) begin
                foreach (frame_q[i]) word = (word << 8) | 16'(frame_q[i]);
                frame_q.delete();
                done = 1'b1;
            end
        end else if (frame_q.size() != 0) begin
            if (idle == T - 1) begin
                m_to = 1'b1;
                frame_q.delete();
                idle = 0;
            end else begin
                idle++;
            end
        end
        if (done) begin
            if (!m_rdy || c) begin
                m_cmd = word;
                m_rdy = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (c) begin
            m_rdy = 1'b0;
        end
    endtask

    // One clock on the 2-byte instance; entered and left 1 time unit after a rising edge.
    task automatic step(input logic r, input logic [7:0] d, input logic c);
        b2.rdy         = r;
        b2.rx_data     = d;
        b2.clr_cmd_rdy = c;
        #1;
        check("clr_rdy", 32'(b2.clr_rdy), 32'(r));
        model_cycle(r, d, c);
        @(posedge clk);
        #1;
        b2.rdy         = 1'b0;
        b2.clr_cmd_rdy = 1'b0;
        check("cmd",     32'(b2.cmd),     32'(m_cmd));
        check("cmd_rdy", 32'(b2.cmd_rdy), 32'(m_rdy));
        check("overrun", 32'(b2.overrun), 32'(m_ovr));
        check("timeout", 32'(b2.timeout), 32'(m_to));
    endtask

    typedef struct {
        logic        rdy;
        logic [7:0]  data;
        logic        clr;
        logic        exp_rdy;
        logic [15:0] exp_cmd;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int k;
        logic [7:0] bytes4[4];

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 16'h0102, 1'b0};
        tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 16'h0102, 1'b0};
        tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b1, 16'h0102, 1'b1};
        tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 16'h0102, 1'b0};
        tbl[6]  = '{1'b1, 8'h06, 1'b1, 1'b1, 16'h0506, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0506, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0506, 1'b0};
        tbl[9]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 16'h0506, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0506, 1'b0};
        tbl[11] = '{1'b1, 8'h3C, 1'b0, 1'b1, 16'hA53C, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA53C, 1'b0};

        rst_n = 1'b0;
        b2.rdy = 1'b0; b2.rx_data = '0; b2.clr_cmd_rdy = 1'b0;
        b1.rdy = 1'b0; b1.rx_data = '0; b1.clr_cmd_rdy = 1'b0;
        b4.rdy = 1'b0; b4.rx_data = '0; b4.clr_cmd_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset cmd",     32'(b2.cmd),     32'h0);
        check("reset cmd_rdy", 32'(b2.cmd_rdy), 32'h0);
        check("reset overrun", 32'(b2.overrun), 32'h0);
        check("reset timeout", 32'(b2.timeout), 32'h0);
        rst_n = 1'b1;

        // Single-byte frames complete on the capture clock.
        b1.rdy = 1'b1; b1.rx_data = 8'h7E;
        #1;
        check("nb1 clr_rdy", 32'(b1.clr_rdy), 32'h1);
        @(posedge clk); #1;
        b1.rdy = 1'b0;
        check("nb1 cmd",     32'(b1.cmd),     32'h7E);
        check("nb1 cmd_rdy", 32'(b1.cmd_rdy), 32'h1);

        bytes4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            b4.rdy = 1'b1; b4.rx_data = bytes4[i];
            @(posedge clk); #1;
            b4.rdy = 1'b0;
            if (i == 2) check("nb4 cmd_rdy early", 32'(b4.cmd_rdy), 32'h0);
        end
        check("nb4 cmd",     32'(b4.cmd),     32'hDEADBEEF);
        check("nb4 cmd_rdy", 32'(b4.cmd_rdy), 32'h1);

        // Vector table: overrun, coincident ack, idle ack, basic frame.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rdy, tbl[i].data, tbl[i].clr);
            check($sformatf("tbl%0d cmd", i),     32'(b2.cmd),     32'(tbl[i].exp_cmd));
            check($sformatf("tbl%0d cmd_rdy", i), 32'(b2.cmd_rdy), 32'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d overrun", i), 32'(b2.overrun), 32'(tbl[i].exp_ovr));
        end

        // Basic frame with a long (sub-timeout) gap.
        step(1'b1, 8'hA5, 1'b0);
        repeat (100) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        check("gap cmd", 32'(b2.cmd), 32'hA53C);
        step(1'b0, 8'h00, 1'b1);
        check("gap ack cmd_rdy", 32'(b2.cmd_rdy), 32'h0);
        check("gap ack cmd",     32'(b2.cmd),     32'hA53C);

        // Timeout: pulse appears after the T-th idle clock following the capture.
        step(1'b1, 8'h11, 1'b0);
        k = 0;
        for (int i = 1; i <= 2 * T; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (b2.timeout) begin
                k = i;
                break;
            end
        end
        check("timeout idle clocks", 32'(k), 32'(T));
        check("timeout cmd_rdy", 32'(b2.cmd_rdy), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        check("timeout single pulse", 32'(b2.timeout), 32'h0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        check("post-timeout cmd", 32'(b2.cmd), 32'h2233);

        // Second byte on the terminal-count cycle is accepted.
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h44, 1'b0);
        repeat (T - 1) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check("boundary timeout", 32'(b2.timeout), 32'h0);
        check("boundary cmd",     32'(b2.cmd),     32'h4455);
        check("boundary cmd_rdy", 32'(b2.cmd_rdy), 32'h1);

        // Asynchronous reset mid-frame while a command is held.
        step(1'b1, 8'hFF, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst cmd",     32'(b2.cmd),     32'h0);
        check("async rst cmd_rdy", 32'(b2.cmd_rdy), 32'h0);
        check("async rst timeout", 32'(b2.timeout), 32'h0);
        check("async rst overrun", 32'(b2.overrun), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        check("post-reset cmd", 32'(b2.cmd), 32'h1234);

        // Randomized traffic; some gaps straddle the timeout boundary.
        for (int i = 0; i < 400; i++) begin
            int gap;
            gap = ($urandom % 8 == 0) ? int'($urandom_range(T + 2, T - 3)) : int'($urandom_range(5, 0));
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, ($urandom % 4) == 0);
            step(1'b1, 8'($urandom), ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
